// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift controller: FSM state type,
// shift-register mode select encodings and default sizes.
package shift_ctrl_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_CNT_W = 3;

   // Mode select for the shift register datapath
   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_LEFT  = 2'b01;
   localparam logic [1:0] SEL_RIGHT = 2'b10;
   localparam logic [1:0] SEL_LOAD  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/shift_reg4.sv
// Shift register datapath: hold, single-bit shift left/right with
// zero fill, or parallel load, selected by sel.
module shift_reg4
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q
);

   // Register update: reset clears contents, otherwise apply the selected mode
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else begin
         case (sel)
            SEL_LEFT:  q <= {q[WIDTH-2:0], 1'b0};
            SEL_RIGHT: q <= {1'b0, q[WIDTH-1:1]};
            SEL_LOAD:  q <= din;
            default:   q <= q;
         endcase
      end
   end

endmodule

// File: rtl/shift_ctrl.sv
// Command sequencer for a shift register: accepts a command (optional
// load, direction, shift count), steps the datapath one bit per cycle
// with pause support, and pulses done on completion.
module shift_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             pause,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             dir_q;
   logic [WIDTH-1:0] data_q;
   logic [1:0]       sel;
   logic             accept;

   assign accept    = (state == S_IDLE) && cmd_valid;
   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   // State and remaining-count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   // Command capture: direction and load data are frozen at acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q  <= 1'b0;
         data_q <= '0;
      end else if (accept) begin
         dir_q  <= cmd_op[1];
         data_q <= cmd_data;
      end
   end

   // Next-state, count and datapath select; the last shift is issued
   // in the same cycle the FSM moves to DONE
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_q;
      sel       = SEL_HOLD;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               cnt_nxt = cmd_cnt;
               if (cmd_op[0])
                  state_nxt = S_LOAD;
               else if (cmd_cnt != '0)
                  state_nxt = S_SHIFT;
               else
                  state_nxt = S_DONE;
            end
         end
         S_LOAD: begin
            sel       = SEL_LOAD;
            state_nxt = (cnt_q != '0) ? S_SHIFT : S_DONE;
         end
         S_SHIFT: begin
            if (!pause) begin
               sel     = dir_q ? SEL_RIGHT : SEL_LEFT;
               cnt_nxt = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1))
                  state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   shift_reg4 #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .sel (sel),
      .din (data_q),
      .q   (dout)
   );

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: command sequences with hand-computed
// register contents and handshake/status values cycle by cycle.
module tb_shift_ctrl;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [2:0] cmd_cnt;
   logic [3:0] cmd_data;
   logic       pause;
   logic [3:0] dout;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .cmd_data  (cmd_data),
      .pause     (pause),
      .dout      (dout),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // dout, busy, cmd_ready, done in one call
   task automatic chk_all(input string tag, input logic [3:0] d, input logic b,
                          input logic r, input logic dn);
      chk({tag, ".dout"},  32'(dout),      32'(d));
      chk({tag, ".busy"},  32'(busy),      32'(b));
      chk({tag, ".ready"}, 32'(cmd_ready), 32'(r));
      chk({tag, ".done"},  32'(done),      32'(dn));
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_data  = data;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 3'd0;
      cmd_data = 4'h0; pause = 1'b0;
      step();
      step();
      chk_all("rst_hold", 4'b0000, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      step();
      chk_all("rst_rel", 4'b0000, 1'b0, 1'b1, 1'b0);

      // load 1011, shift left by 2
      issue(2'b01, 3'd2, 4'b1011);
      chk_all("l2_load", 4'b0000, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l2_n2", 4'b1011, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l2_n3", 4'b0110, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l2_n4", 4'b1100, 1'b1, 1'b0, 1'b1);
      step(); chk_all("l2_idle", 4'b1100, 1'b0, 1'b1, 1'b0);

      // no-load right by 3 on 1100, with a two-cycle pause
      issue(2'b10, 3'd3, 4'b1111);
      chk_all("r3_n1", 4'b1100, 1'b1, 1'b0, 1'b0);
      step(); chk_all("r3_n2", 4'b0110, 1'b1, 1'b0, 1'b0);
      pause = 1'b1;
      step(); chk_all("r3_p1", 4'b0110, 1'b1, 1'b0, 1'b0);
      step(); chk_all("r3_p2", 4'b0110, 1'b1, 1'b0, 1'b0);
      pause = 1'b0;
      step(); chk_all("r3_n5", 4'b0011, 1'b1, 1'b0, 1'b0);
      step(); chk_all("r3_n6", 4'b0001, 1'b1, 1'b0, 1'b1);
      step(); chk_all("r3_idle", 4'b0001, 1'b0, 1'b1, 1'b0);

      // load 1001, right by 1; pause high through IDLE and LOAD has no effect
      pause = 1'b1;
      issue(2'b11, 3'd1, 4'b1001);
      chk_all("r1_load", 4'b0001, 1'b1, 1'b0, 1'b0);
      pause = 1'b0;
      step(); chk_all("r1_n2", 4'b1001, 1'b1, 1'b0, 1'b0);
      step(); chk_all("r1_n3", 4'b0100, 1'b1, 1'b0, 1'b1);
      step(); chk_all("r1_idle", 4'b0100, 1'b0, 1'b1, 1'b0);

      // load-only with cmd_valid held high; data changed while busy is ignored
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 3'd0; cmd_data = 4'b0111;
      step(); chk_all("l0_n1", 4'b0100, 1'b1, 1'b0, 1'b0);
      cmd_data = 4'b1010;
      step(); chk_all("l0_n2", 4'b0111, 1'b1, 1'b0, 1'b1);
      cmd_data = 4'b0111;
      step(); chk_all("l0_idle", 4'b0111, 1'b0, 1'b1, 1'b0);
      step(); chk_all("l0_again", 4'b0111, 1'b1, 1'b0, 1'b0);
      cmd_valid = 1'b0;
      step(); chk_all("l0_again_done", 4'b0111, 1'b1, 1'b0, 1'b1);
      step(); chk_all("l0_again_idle", 4'b0111, 1'b0, 1'b1, 1'b0);

      // load 1111, left by 5 (more than WIDTH)
      issue(2'b01, 3'd5, 4'b1111);
      chk_all("l5_load", 4'b0111, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l5_n2", 4'b1111, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l5_n3", 4'b1110, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l5_n4", 4'b1100, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l5_n5", 4'b1000, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l5_n6", 4'b0000, 1'b1, 1'b0, 1'b0);
      step(); chk_all("l5_n7", 4'b0000, 1'b1, 1'b0, 1'b1);
      step(); chk_all("l5_idle", 4'b0000, 1'b0, 1'b1, 1'b0);

      // reset during SHIFT wins over cmd_valid and pause
      issue(2'b01, 3'd4, 4'b0101);
      step(); chk_all("rs_n2", 4'b0101, 1'b1, 1'b0, 1'b0);
      step(); chk_all("rs_n3", 4'b1010, 1'b1, 1'b0, 1'b0);
      rst = 1'b1; cmd_valid = 1'b1; pause = 1'b1;
      step(); chk_all("rs_abort", 4'b0000, 1'b0, 1'b1, 1'b0);
      rst = 1'b0; cmd_valid = 1'b0; pause = 1'b0;
      step(); chk_all("rs_after", 4'b0000, 1'b0, 1'b1, 1'b0);

      // no-load, zero count: straight to DONE
      issue(2'b00, 3'd0, 4'b1111);
      chk_all("z0_n1", 4'b0000, 1'b1, 1'b0, 1'b1);
      step(); chk_all("z0_idle", 4'b0000, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, data width of the controlled shift register.
REQ-002 Parameter CNT_W, default 3, width of the shift-count field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_op  input  2  bit0 = load before shifting; bit1 = direction (0 left, 1 right).
REQ-008 cmd_cnt  input  CNT_W  number of single-bit shifts, 0..7.
REQ-009 cmd_data  input  WIDTH  parallel load value, used only when cmd_op[0]=1.
REQ-010 pause  input  1  freezes shifting while high.
REQ-011 dout  output  WIDTH  current shift-register contents, continuously driven.
REQ-012 busy  output  1  command in progress (any state other than IDLE).
REQ-013 done  output  1  one-cycle pulse at command completion.

Function
REQ-014 The block SHALL sequence an internal WIDTH-bit shift register whose mode select uses: 00 hold, 01 shift left (zero-fill at LSB), 10 shift right (zero-fill at MSB), 11 parallel load.
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted in a cycle where cmd_valid and cmd_ready are both 1, and cmd_op, cmd_cnt and cmd_data are captured that cycle.
REQ-017 cmd_valid while cmd_ready=0 SHALL be ignored with no side effect.
REQ-018 From IDLE on acceptance: next state LOAD if cmd_op[0]=1; else SHIFT if cmd_cnt>0; else DONE.
REQ-019 LOAD SHALL last exactly one cycle with select=11 and load data = captured cmd_data; next state SHIFT if captured count>0, else DONE.
REQ-020 In SHIFT with pause=0, select SHALL be 01 (dir=0) or 10 (dir=1) and the remaining count decrements by 1; transition to DONE on the cycle the last shift is issued (remaining count 1).
REQ-021 In SHIFT with pause=1, select SHALL be 00 and the remaining count SHALL hold.
REQ-022 In IDLE and DONE, select SHALL be 00; register contents hold.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 Latency: command accepted at cycle N with load and count C, pause low -> done=1 at cycle N+2+C; without load -> done at N+1+C; dout reflects the final value in the done cycle.
REQ-025 Counts >= WIDTH SHALL be performed literally, yielding all zeros.
REQ-026 pause SHALL have no effect outside SHIFT.
REQ-027 dout SHALL retain its value between commands (no-load commands operate on the previous contents).

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, dout=0, remaining count 0, captured command cleared, done=0, busy=0, and cmd_ready=1 in the following cycle.
REQ-029 Reset mid-command (LOAD or SHIFT) SHALL abort the command with no done pulse.
REQ-030 Reset SHALL take priority over cmd_valid and pause in the same cycle.

Structure
REQ-031 Package shift_ctrl_pkg SHALL hold the FSM state type, the four select encodings, and default WIDTH/CNT_W constants.
REQ-032 The register datapath SHALL be one sub-module, shift_reg4 (clk, rst, sel, din, q), instantiated once; shift_ctrl contains only FSM, count, and capture registers.

Verification
REQ-033 Reset then op=01 (load, left), cnt=2, data=0b1011 -> LOAD dout=1011, then 0110, 1100; done at N+4, dout=1100.
REQ-034 op=11 (load, right), cnt=1, data=0b1001 -> dout 1001 then 0100; done at N+3.
REQ-035 After dout=1100, op=10 (right, no load), cnt=3, pause high 2 cycles mid-shift -> dout 0110, hold 2 cycles, 0011, 0001; done at N+6.
REQ-036 op=01, cnt=0, data=0b0111 -> load only, done at N+2, dout=0111; cmd_valid held high throughout is accepted again only after return to IDLE.
REQ-037 op=01, cnt=5, data=0b1111 -> dout reaches 0000 after 4 shifts, done at N+7.
REQ-038 rst asserted during SHIFT -> next cycle dout=0, busy=0, cmd_ready=1, no done pulse.
